conv_pool_engine: RTL and testbench
===================================

Name: conv_pool_engine

Overview:
Parametrised pooling engine that follows the CONV layer-0 convolution stage. It reads convolution results from layer-0 memory through the shared crd/caddr_rd/cdata_rd/csel port and computes POOLxPOOL non-overlapping windows. It supports three modes: max, max+ReLU, and average. It writes pooled results to layer-1 memory through cwr/caddr_wr/cdata_wr, and processes 1 or 2 channels back to back under a start/busy/done handshake.

Parameters:
DATA_W, 20, sample width, signed two's complement (Q-format opaque to block)
IMG_W, 64, input image width in pixels (power of two)
IMG_H, 64, input image height in pixels (power of two)
POOL, 2, window edge; legal values 2 or 4
CH, 1, channel count; legal values 1 or 2
ADDR_W, 12, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
L0_SEL, 3'b001, csel code for reading layer-0 memory of channel 0
L1_SEL, 3'b011, csel code for writing layer-1 memory of channel 0

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to run one full pass over all channels
mode  in  2  00 max, 01 max then ReLU, 10 average, 11 treated as 00
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse on the cycle after the final write
crd  out  1  memory read strobe
caddr_rd  out  ADDR_W  read address
cdata_rd  in  DATA_W  read data; valid on the rising edge one cycle after crd
cwr  out  1  memory write strobe
caddr_wr  out  ADDR_W  write address
cdata_wr  out  DATA_W  write data
csel  out  3  memory select; channel k read = L0_SEL + 4k, write = L1_SEL + 4k; 0 when idle

Behaviour:
- Reset: on the clk edge with reset=1, all outputs go to 0 and the FSM goes to IDLE. Any in-progress window is discarded and no partial write is issued. Reset overrides start.
- FSM states: IDLE, READ, DRAIN, WRITE, FIN.
- IDLE:
  - start=1 latches mode, clears the counters (ch, oy, ox, k) and enters READ.
  - busy rises on that same edge.
- READ: issues N=POOL*POOL reads on consecutive cycles with crd=1.
  - Read order: dy outer, dx inner.
  - caddr_rd = (oy*POOL+dy)*IMG_W + ox*POOL + dx.
  - Accumulator update uses cdata_rd of the previous read, so the first sample is taken one cycle after the first crd.
  - After the N-th read issues, go to DRAIN (crd=0).
- DRAIN: absorbs the last sample, then goes to WRITE.
- WRITE: one cycle with cwr=1.
  - caddr_wr = oy*(IMG_W/POOL) + ox; cdata_wr = result.
  - Advance ox, then oy, then ch.
  - If more windows remain, go to READ; after the last window of the last channel, go to FIN.
- FIN: busy=0 and done=1 for exactly one cycle, then IDLE.
- Throughput: N+2 cycles per output. Full pass = CH*(IMG_W/POOL)*(IMG_H/POOL)*(N+2) cycles, plus 1 for FIN. Defaults give 4096*6/4 = 6144 cycles busy.
- crd and cwr are never high in the same cycle. csel is stable and correct in every cycle where crd or cwr is high.
- Arithmetic:
  - Max: signed comparison; the first sample of a window initialises the running max.
  - ReLU: applied after max; a negative result is written as 0.
  - Average:
    - Signed sum uses DATA_W+4 bits.
    - Result = sum >>> log2(N) (arithmetic shift, floor), truncated to DATA_W.
    - Overflow is impossible by construction.
- Handshake: start is ignored while busy=1 or in FIN. A start held high in IDLE after FIN launches a new pass. mode changes during busy have no effect.
- Address wrap: counters are sized exactly. No address exceeds IMG_W*IMG_H-1 (read) or (IMG_W*IMG_H)/N-1 (write).

Test Plan:
1. Defaults, mode 00, pixel p = p (ramp 0..4095) -> output(0)=65, output(1)=67, output(1023)=4095; exactly 1024 writes, csel 001/011 only; busy high 6144 cycles; done single pulse.
2. Mode 01, window {-5,-3,-8,-1} at (0,0) -> cdata_wr=0; window {-5,7,-8,2} -> 7.
3. Mode 10, window {3,4,4,4} -> 3 (sum 15 >>> 2); window {-1,0,0,0} -> -1 (0xFFFFF, floor).
4. CH=2, POOL=4, 64x64 ramp, mode 00 -> 256 writes with csel=011 then 256 with csel=111; reads csel 001 then 101; first output = 195.
5. Pulse start at cycle 100 of a pass -> no restart, counters unaffected, done exactly once.
6. Assert reset for 1 cycle mid-WRITE -> all outputs 0 next edge, no further cwr; a new start gives a correct full pass from address 0.

Source files
------------

// File: rtl/conv_pool_engine_if.sv
// conv_pool_engine_if: control handshake and memory bus of the pooling engine.
//   start/mode     : pass request and pooling mode (toward engine)
//   busy/done      : pass in progress / one-cycle completion pulse (from engine)
//   crd/caddr_rd   : layer-0 read strobe and address (from engine)
//   cdata_rd       : layer-0 read data, one cycle after crd (toward engine)
//   cwr/caddr_wr/cdata_wr : layer-1 write strobe, address, data (from engine)
//   csel           : memory select (from engine)
// Modport master is the engine side; slave is the memory/controller side.
interface conv_pool_engine_if #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic [2:0]        csel;

    modport master (
        input  start, mode, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, mode, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/conv_pool_engine.sv
// conv_pool_engine: POOLxPOOL non-overlapping pooling over the layer-0 convolution
// output, written to layer-1 memory. Modes: max, max+ReLU, average (floor).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : conv_pool_engine_if.master (start/mode/busy/done handshake and the
//           crd/caddr_rd/cdata_rd, cwr/caddr_wr/cdata_wr, csel memory bus)
module conv_pool_engine #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned POOL   = 2,
    parameter int unsigned CH     = 1,
    parameter int unsigned ADDR_W = 12,
    parameter logic [2:0]  L0_SEL = 3'b001,
    parameter logic [2:0]  L1_SEL = 3'b011
) (
    input logic                 clk,
    input logic                 reset,
    conv_pool_engine_if.master  bus
);

    localparam int unsigned N     = POOL * POOL;
    localparam int unsigned PL    = $clog2(POOL);
    localparam int unsigned LOG_N = 2 * PL;
    localparam int unsigned K_W   = LOG_N;
    localparam int unsigned OW    = IMG_W / POOL;
    localparam int unsigned OH    = IMG_H / POOL;
    localparam int unsigned OX_W  = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned OY_W  = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned ACC_W = DATA_W + 4;

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StFin} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic                     ch_q, ch_d;
    logic [OY_W-1:0]          oy_q, oy_d;
    logic [OX_W-1:0]          ox_q, ox_d;
    logic [K_W-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    // Sample strobes trail crd by one cycle, matching the memory read latency.
    logic                     rd_vld_q;
    logic                     first_q;

    logic                     ox_last, oy_last, ch_last;
    logic                     is_avg, is_relu;
    logic signed [ACC_W-1:0]  samp_ext;
    logic [DATA_W-1:0]        avg_res;
    logic [DATA_W-1:0]        result;
    logic [PL-1:0]            dy, dx;

    assign ox_last  = (ox_q == OX_W'(OW - 1));
    assign oy_last  = (oy_q == OY_W'(OH - 1));
    assign ch_last  = (ch_q == 1'(CH - 1));
    assign is_avg   = (mode_q == 2'b10);
    assign is_relu  = (mode_q == 2'b01);
    assign samp_ext = {{(ACC_W - DATA_W){bus.cdata_rd[DATA_W-1]}}, bus.cdata_rd};
    assign avg_res  = DATA_W'(acc_q >>> LOG_N);
    assign dy       = k_q[K_W-1:PL];
    assign dx       = k_q[PL-1:0];

    always_comb begin
        result = is_avg ? avg_res : acc_q[DATA_W-1:0];
        if (is_relu && acc_q[ACC_W-1]) begin
            result = '0;
        end
    end

    // Accumulator: first sample of a window seeds both the max and the sum.
    always_comb begin
        acc_d = acc_q;
        if (rd_vld_q) begin
            if (first_q) begin
                acc_d = samp_ext;
            end else if (is_avg) begin
                acc_d = acc_q + samp_ext;
            end else if (samp_ext > acc_q) begin
                acc_d = samp_ext;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ch_d    = ch_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRead;
                    mode_d  = bus.mode;
                    ch_d    = 1'b0;
                    oy_d    = '0;
                    ox_d    = '0;
                    k_d     = '0;
                end
            end
            StRead: begin
                // k wraps to 0 after the last read since N is a power of two.
                k_d = k_q + K_W'(1);
                if (k_q == K_W'(N - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StWrite;
            StWrite: begin
                state_d = StRead;
                if (ox_last) begin
                    ox_d = '0;
                    if (oy_last) begin
                        oy_d = '0;
                        if (ch_last) begin
                            ch_d    = 1'b0;
                            state_d = StFin;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        oy_d = oy_q + OY_W'(1);
                    end
                end else begin
                    ox_d = ox_q + OX_W'(1);
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mode_q   <= 2'b00;
            ch_q     <= 1'b0;
            oy_q     <= '0;
            ox_q     <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ch_q     <= ch_d;
            oy_q     <= oy_d;
            ox_q     <= ox_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            rd_vld_q <= (state_q == StRead);
            first_q  <= (state_q == StRead) && (k_q == '0);
        end
    end

    // Outputs decode from registered state only; addresses and data read as
    // zero outside their strobe so an idle or reset engine drives all zeros.
    always_comb begin
        bus.busy     = (state_q == StRead) || (state_q == StDrain) || (state_q == StWrite);
        bus.done     = (state_q == StFin);
        bus.crd      = (state_q == StRead);
        bus.cwr      = (state_q == StWrite);
        bus.caddr_rd = '0;
        bus.caddr_wr = '0;
        bus.cdata_wr = '0;
        bus.csel     = 3'b000;
        if (state_q == StRead || state_q == StDrain) begin
            bus.csel = L0_SEL + {ch_q, 2'b00};
        end
        if (state_q == StRead) begin
            // Powers of two: concatenation equals (oy*POOL+dy)*IMG_W + ox*POOL+dx.
            bus.caddr_rd = ADDR_W'({oy_q, dy, ox_q, dx});
        end
        if (state_q == StWrite) begin
            bus.csel     = L1_SEL + {ch_q, 2'b00};
            bus.caddr_wr = ADDR_W'({oy_q, ox_q});
            bus.cdata_wr = result;
        end
    end

endmodule

// File: tb/tb_conv_pool_engine.sv
module tb_conv_pool_engine;
    localparam int DW = 20;
    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    sel;
        logic [2:0]    rsel;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_pool_engine_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
    conv_pool_engine_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

    conv_pool_engine #(
        .DATA_W(DW), .IMG_W(64), .IMG_H(64), .POOL(2), .CH(1), .ADDR_W(AW),
        .L0_SEL(3'b001), .L1_SEL(3'b011)
    ) u_a (
        .clk(clk), .reset(rst), .bus(a_if)
    );

    conv_pool_engine #(
        .DATA_W(DW), .IMG_W(64), .IMG_H(64), .POOL(4), .CH(2), .ADDR_W(AW),
        .L0_SEL(3'b001), .L1_SEL(3'b011)
    ) u_b (
        .clk(clk), .reset(rst), .bus(b_if)
    );

    logic signed [DW-1:0] mem_a [4096];
    logic signed [DW-1:0] mem_b [2][4096];
    logic [DW-1:0]        out_a [1024];
    logic [DW-1:0]        b_first;
    wr_t  qa[$];
    wr_t  qb[$];
    wr_t  ea, eb;
    int   checks = 0;
    int   failures = 0;
    int   a_busy, a_done, a_wr;
    int   b_busy, b_done, b_wr0, b_wr1;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pooling straight from the window definition.
    function automatic logic [DW-1:0] ref_win(bit use_b, int ch, int pool, int md,
                                              int oy, int ox);
        longint s = 0;
        longint mx = 0;
        longint v;
        longint r;
        int     a;
        for (int dy = 0; dy < pool; dy++) begin
            for (int dx = 0; dx < pool; dx++) begin
                a = (oy * pool + dy) * 64 + ox * pool + dx;
                v = use_b ? longint'(mem_b[ch][a]) : longint'(mem_a[a]);
                s += v;
                if ((dy == 0 && dx == 0) || v > mx) mx = v;
            end
        end
        if (md == 2) begin
            r = s >>> ((pool == 2) ? 2 : 4);
        end else begin
            r = mx;
            if (md == 1 && r < 0) r = 0;
        end
        return r[DW-1:0];
    endfunction

    // Layer-0 memories: data returned on the edge after crd.
    always @(posedge clk) begin
        if (a_if.crd === 1'b1) a_if.cdata_rd <= mem_a[a_if.caddr_rd];
        if (b_if.crd === 1'b1) b_if.cdata_rd <= mem_b[b_if.csel[2]][b_if.caddr_rd];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_if.busy) a_busy++;
            if (a_if.done) a_done++;
            if (a_if.crd || a_if.cwr) chk("a_rd_wr_excl", 32'(a_if.crd & a_if.cwr), 0);
            if (a_if.crd) chk("a_rd_csel", 32'(a_if.csel), 3'b001);
            if (a_if.cwr) begin
                a_wr++;
                chk("a_wr_expected", 32'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("a_wr_addr", 32'(a_if.caddr_wr), 32'(ea.addr));
                    chk("a_wr_data", 32'(a_if.cdata_wr), 32'(ea.data));
                    chk("a_wr_csel", 32'(a_if.csel), 32'(ea.sel));
                end
                out_a[a_if.caddr_wr[9:0]] = a_if.cdata_wr;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_if.busy) b_busy++;
            if (b_if.done) b_done++;
            if (b_if.crd || b_if.cwr) chk("b_rd_wr_excl", 32'(b_if.crd & b_if.cwr), 0);
            if (b_if.crd && qb.size() > 0) chk("b_rd_csel", 32'(b_if.csel), 32'(qb[0].rsel));
            if (b_if.cwr) begin
                if (b_if.csel == 3'b011) b_wr0++;
                if (b_if.csel == 3'b111) b_wr1++;
                chk("b_wr_expected", 32'(qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    if (qb.size() == 512) b_first = b_if.cdata_wr;
                    eb = qb.pop_front();
                    chk("b_wr_addr", 32'(b_if.caddr_wr), 32'(eb.addr));
                    chk("b_wr_data", 32'(b_if.cdata_wr), 32'(eb.data));
                    chk("b_wr_csel", 32'(b_if.csel), 32'(eb.sel));
                end
            end
        end
    end

    task automatic push_a(input int md);
        for (int oy = 0; oy < 32; oy++)
            for (int ox = 0; ox < 32; ox++)
                qa.push_back('{addr: AW'(oy * 32 + ox), data: ref_win(0, 0, 2, md, oy, ox),
                               sel: 3'b011, rsel: 3'b001});
    endtask

    task automatic wait_done_a();
        bit seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (a_if.done) seen = 1'b1;
        end
        chk("a_done_seen", 32'(seen), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic start_a(input logic [1:0] md);
        a_busy = 0; a_done = 0; a_wr = 0;
        @(posedge clk); #1;
        a_if.mode  = md;
        a_if.start = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        a_if.mode  = md ^ 2'b10;   // must not affect the running pass
    endtask

    task automatic run_a(input logic [1:0] md, input bit pulse);
        push_a(int'(md));
        start_a(md);
        if (pulse) begin
            repeat (98) @(posedge clk);
            #1 a_if.start = 1'b1;
            @(posedge clk); #1 a_if.start = 1'b0;
        end
        wait_done_a();
        chk("a_busy_cycles", a_busy, 6144);
        chk("a_done_pulses", a_done, 1);
        chk("a_write_count", a_wr, 1024);
        chk("a_queue_drained", qa.size(), 0);
    endtask

    task automatic ramp_a();
        for (int p = 0; p < 4096; p++) mem_a[p] = DW'(p);
    endtask

    initial begin
        int cnt;
        int snap;
        bit seen;
        rst = 1'b1;
        a_if.start = 1'b0; a_if.mode = 2'b00;
        b_if.start = 1'b0; b_if.mode = 2'b00;
        ramp_a();
        for (int p = 0; p < 4096; p++) begin
            mem_b[0][p] = DW'(p);
            mem_b[1][p] = DW'(p + 10000);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_a_busy", 32'(a_if.busy), 0);
        chk("rst_a_done", 32'(a_if.done), 0);
        chk("rst_a_crd_cwr", 32'({a_if.crd, a_if.cwr}), 0);
        chk("rst_a_csel", 32'(a_if.csel), 0);
        chk("rst_b_busy", 32'(b_if.busy), 0);
        chk("rst_b_csel", 32'(b_if.csel), 0);
        mon_en = 1'b1;

        // Max mode over ramp, with a stray start pulse mid-pass.
        run_a(2'b00, 1'b1);
        chk("t1_out0", 32'(out_a[0]), 65);
        chk("t1_out1", 32'(out_a[1]), 67);
        chk("t1_out1023", 32'(out_a[1023]), 4095);

        // Max + ReLU.
        mem_a[0] = -20'sd5; mem_a[1] = -20'sd3; mem_a[64] = -20'sd8; mem_a[65] = -20'sd1;
        mem_a[2] = -20'sd5; mem_a[3] = 20'sd7;  mem_a[66] = -20'sd8; mem_a[67] = 20'sd2;
        run_a(2'b01, 1'b0);
        chk("t2_relu_neg", 32'(out_a[0]), 0);
        chk("t2_relu_pos", 32'(out_a[1]), 7);

        // Average with floor.
        mem_a[0] = 20'sd3;  mem_a[1] = 20'sd4; mem_a[64] = 20'sd4; mem_a[65] = 20'sd4;
        mem_a[2] = -20'sd1; mem_a[3] = 20'sd0; mem_a[66] = 20'sd0; mem_a[67] = 20'sd0;
        run_a(2'b10, 1'b0);
        chk("t3_avg_pos", 32'(out_a[0]), 3);
        chk("t3_avg_floor", 32'(out_a[1]), 32'h000FFFFF);

        // Reset during a write, then a clean pass.
        ramp_a();
        push_a(0);
        start_a(2'b00);
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 3; i++) begin
            @(negedge clk);
            if (a_if.cwr) cnt++;
        end
        chk("t6_reached_write", cnt, 3);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t6_busy", 32'(a_if.busy), 0);
        chk("t6_done", 32'(a_if.done), 0);
        chk("t6_strobes", 32'({a_if.crd, a_if.cwr}), 0);
        chk("t6_csel", 32'(a_if.csel), 0);
        chk("t6_addr_data", 32'({a_if.caddr_rd, a_if.caddr_wr}) | 32'(a_if.cdata_wr), 0);
        qa.delete();
        snap = a_wr;
        repeat (20) @(negedge clk);
        chk("t6_no_wr_after_reset", a_wr - snap, 0);
        run_a(2'b00, 1'b0);
        chk("t6_out0", 32'(out_a[0]), 65);

        // Two channels, 4x4 windows.
        for (int c = 0; c < 2; c++)
            for (int oy = 0; oy < 16; oy++)
                for (int ox = 0; ox < 16; ox++)
                    qb.push_back('{addr: AW'(oy * 16 + ox), data: ref_win(1, c, 4, 0, oy, ox),
                                   sel: (c == 0) ? 3'b011 : 3'b111,
                                   rsel: (c == 0) ? 3'b001 : 3'b101});
        b_busy = 0; b_done = 0; b_wr0 = 0; b_wr1 = 0;
        @(posedge clk); #1 b_if.mode = 2'b00; b_if.start = 1'b1;
        @(posedge clk); #1 b_if.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(negedge clk);
            if (b_if.done) seen = 1'b1;
        end
        chk("b_done_seen", 32'(seen), 1);
        repeat (4) @(negedge clk);
        chk("b_busy_cycles", b_busy, 9216);
        chk("b_done_pulses", b_done, 1);
        chk("b_ch0_writes", b_wr0, 256);
        chk("b_ch1_writes", b_wr1, 256);
        chk("b_first_out", 32'(b_first), 195);
        chk("b_queue_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
